// File: rtl/video_pattern_gen_pkg.sv
// Shared video definitions: the YCbCr pixel layout, reference colours,
// test-pattern encodings and the control-word layout used by the VIP blocks.
package video_pattern_gen_pkg;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } pixel_t;

    localparam pixel_t BLACK = 24'h008080;
    localparam pixel_t WHITE = 24'hFF8080;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_GRADIENT = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_SOLID    = 2'd3
    } pattern_e;

    // Control word: {width[15:0], height[15:0], pattern[1:0], reserved[1:0]}
    function automatic logic [35:0] ctrl_word(input logic [15:0] width,
                                              input logic [15:0] height,
                                              input logic [1:0]  pattern);
        return {width, height, pattern, 2'b00};
    endfunction

endpackage

// File: rtl/video_pattern_gen_pattern_pixel.sv
// Combinational pixel colouring for the test patterns; the caller supplies
// the low x bits, the y parity, the checker phase and the bar index.
module pattern_pixel
    import video_pattern_gen_pkg::*;
(
    input  logic [7:0]  x_lo_i,
    input  logic        y_odd_i,
    input  logic        check_i,
    input  logic [2:0]  bar_i,
    input  logic [1:0]  pattern_i,
    input  logic [23:0] solid_i,
    output logic [23:0] pixel_o
);

    pixel_t pix_s;

    // Pattern select; chroma stays neutral except for the solid colour.
    always_comb begin
        pix_s = BLACK;
        case (pattern_e'(pattern_i))
            PAT_BARS:     pix_s.y = {bar_i, 5'b11111};
            PAT_GRADIENT: pix_s.y = x_lo_i ^ {8{y_odd_i}};
            PAT_CHECKER: begin
                if (check_i) begin
                    pix_s = WHITE;
                end else begin
                    pix_s = BLACK;
                end
            end
            PAT_SOLID:    pix_s = solid_i;
            default:      pix_s = BLACK;
        endcase
    end

    assign pixel_o = pix_s;

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: control strobe, then one frame of pixels with
// valid/ready flow control, then an idle gap.
module video_pattern_gen
    import video_pattern_gen_pkg::*;
#(
    parameter int WIDTH      = 1920,
    parameter int HEIGHT     = 1080,
    parameter int FRAME_GAP  = 4,
    parameter int CHECK_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_color,
    output logic [23:0] video_out_data,
    output logic        video_out_valid,
    input  logic        video_out_ready,
    output logic        video_out_sop,
    output logic        video_out_eop,
    output logic [35:0] control_out_data,
    output logic        control_out_valid,
    output logic [15:0] frame_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CTRL   = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    localparam int         BAR_LEN  = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;
    localparam logic [15:0] X_LAST   = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST   = 16'(HEIGHT - 1);
    localparam logic [15:0] BAR_LAST = 16'(BAR_LEN - 1);
    localparam logic [15:0] GAP_LAST = 16'(FRAME_GAP - 1);

    logic [1:0]  state_q,      state_d;
    logic [15:0] x_q,          x_d;
    logic [15:0] y_q,          y_d;
    logic [2:0]  bar_q,        bar_d;
    logic [15:0] bar_cnt_q,    bar_cnt_d;
    logic        done_q,       done_d;
    logic [15:0] gap_q,        gap_d;
    logic [1:0]  pattern_q,    pattern_d;
    logic [23:0] solid_q,      solid_d;
    logic [23:0] data_q,       data_d;
    logic        valid_q,      valid_d;
    logic        sop_q,        sop_d;
    logic        eop_q,        eop_d;
    logic [35:0] ctrl_data_q,  ctrl_data_d;
    logic        ctrl_valid_q, ctrl_valid_d;
    logic [15:0] frame_q,      frame_d;

    logic [23:0] pix_s;
    logic        load_s;
    logic        xfer_s;
    logic        first_s;
    logic        last_x_s;
    logic        last_s;

    pattern_pixel u_pattern_pixel (
        .x_lo_i    (x_q[7:0]),
        .y_odd_i   (y_q[0]),
        .check_i   (x_q[CHECK_LOG2] ^ y_q[CHECK_LOG2]),
        .bar_i     (bar_q),
        .pattern_i (pattern_q),
        .solid_i   (solid_q),
        .pixel_o   (pix_s)
    );

    // The counters point at the next pixel to present; the output register
    // refills whenever it is empty or being consumed, until the frame's last
    // pixel has been loaded.
    assign load_s   = (!valid_q || video_out_ready) && !done_q;
    assign xfer_s   = valid_q && video_out_ready;
    assign first_s  = (x_q == 16'd0) && (y_q == 16'd0);
    assign last_x_s = (x_q == X_LAST);
    assign last_s   = last_x_s && (y_q == Y_LAST);

    // Next-state logic for the frame FSM, counters and output registers.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        bar_d        = bar_q;
        bar_cnt_d    = bar_cnt_q;
        done_d       = done_q;
        gap_d        = gap_q;
        pattern_d    = pattern_q;
        solid_d      = solid_q;
        data_d       = data_q;
        valid_d      = valid_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        ctrl_data_d  = ctrl_data_q;
        ctrl_valid_d = 1'b0;
        frame_d      = frame_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_CTRL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CTRL: begin
                pattern_d    = pattern_sel;
                solid_d      = solid_color;
                ctrl_data_d  = ctrl_word(16'(WIDTH), 16'(HEIGHT), pattern_sel);
                ctrl_valid_d = 1'b1;
                x_d          = 16'd0;
                y_d          = 16'd0;
                bar_d        = 3'd0;
                bar_cnt_d    = 16'd0;
                done_d       = 1'b0;
                state_d      = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (load_s) begin
                    data_d  = pix_s;
                    valid_d = 1'b1;
                    sop_d   = first_s;
                    eop_d   = last_s;
                    if (last_s) begin
                        done_d = 1'b1;
                    end else if (last_x_s) begin
                        x_d       = 16'd0;
                        y_d       = y_q + 16'd1;
                        bar_d     = 3'd0;
                        bar_cnt_d = 16'd0;
                    end else begin
                        x_d = x_q + 16'd1;
                        if (bar_cnt_q == BAR_LAST) begin
                            bar_cnt_d = 16'd0;
                            bar_d     = bar_q + 3'd1;
                        end else begin
                            bar_cnt_d = bar_cnt_q + 16'd1;
                        end
                    end
                end else if (xfer_s) begin
                    valid_d = 1'b0;
                    sop_d   = 1'b0;
                    eop_d   = 1'b0;
                    if (eop_q) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LAST;
                        frame_d = frame_q + 16'd1;
                    end else begin
                        state_d = S_ACTIVE;
                    end
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            S_GAP: begin
                if (gap_q == 16'd0) begin
                    if (enable) begin
                        state_d = S_CTRL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_q          <= 16'd0;
            y_q          <= 16'd0;
            bar_q        <= 3'd0;
            bar_cnt_q    <= 16'd0;
            done_q       <= 1'b0;
            gap_q        <= 16'd0;
            pattern_q    <= 2'd0;
            solid_q      <= 24'd0;
            data_q       <= BLACK;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            ctrl_data_q  <= 36'd0;
            ctrl_valid_q <= 1'b0;
            frame_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            bar_q        <= bar_d;
            bar_cnt_q    <= bar_cnt_d;
            done_q       <= done_d;
            gap_q        <= gap_d;
            pattern_q    <= pattern_d;
            solid_q      <= solid_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            ctrl_data_q  <= ctrl_data_d;
            ctrl_valid_q <= ctrl_valid_d;
            frame_q      <= frame_d;
        end
    end

    assign video_out_data    = data_q;
    assign video_out_valid   = valid_q;
    assign video_out_sop     = sop_q;
    assign video_out_eop     = eop_q;
    assign control_out_data  = ctrl_data_q;
    assign control_out_valid = ctrl_valid_q;
    assign frame_count       = frame_q;

endmodule
